id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the RV32I pipeline. It captures the decoded control bundle and operands produced in Decode and presents them to Execute one cycle later.
- Also contains the hazard interlock logic:
  - load-use stall detection;
  - bubble insertion;
  - control-hazard flush on a taken branch or jump resolved in EX.
- Provides saturating stall and flush event counters for performance debug.

Parameters:
- XLEN, 32, datapath width for operands, immediate and PC fields.
- CNT_W, 16, width of each saturating event counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- ctrl_d  input  riscv_pkg::ctrl_s  control bundle from the main decoder
- alu_ctrl_d  input  3  ALU operation from the ALU decoder
- valid_d  input  1  Decode holds a real instruction
- rs1_d  input  5  source register 1 index
- rs2_d  input  5  source register 2 index
- rd_d  input  5  destination register index
- rd1_d  input  XLEN  register file read data 1
- rd2_d  input  XLEN  register file read data 2
- imm_ext_d  input  XLEN  sign-extended immediate
- pc_d  input  XLEN  instruction PC
- pc_plus4_d  input  XLEN  PC+4
- pc_src_e  input  1  taken branch or jump resolved in EX this cycle
- ctrl_e  output  riscv_pkg::ctrl_s  registered control bundle
- alu_ctrl_e  output  3  registered ALU operation
- valid_e  output  1  EX holds a real instruction
- rs1_e, rs2_e, rd_e  output  5 each  registered register indices
- rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e  output  XLEN each  registered data
- stall_f  output  1  hold PC register (combinational)
- stall_d  output  1  hold IF/ID register (combinational)
- flush_d  output  1  squash IF/ID register (combinational)
- stall_cnt  output  CNT_W  count of load-use stall cycles
- flush_cnt  output  CNT_W  count of control flushes

Behaviour:
- Reset (asynchronous, rst=1):
  - all registered outputs clear to zero: ctrl_e='0, valid_e=0, all index and data fields 0, both counters 0;
  - the EX stage therefore holds a bubble.
- Load-use detection (combinational):
  - lu = valid_e & (ctrl_e.ResultSrc==RSRC_MEM) & (rd_e!=0) & valid_d & ((rs1_d==rd_e) | (rs2_d==rd_e));
  - the rs2 match applies for all opcodes; conservative over-stall is accepted.
- Hazard output equations:
  - stall_f = stall_d = lu & ~pc_src_e;
  - flush_d = pc_src_e.
- Capture priority on each rising edge, first match wins:
  1. pc_src_e=1: load a bubble (all fields zero, valid_e=0). The wrong-path instruction in D is discarded.
  2. lu=1: load a bubble. D holds its instruction via stall_d and re-presents it next cycle.
  3. Otherwise: capture all *_d inputs. If valid_d=0, also force ctrl_e='0.
- Latency:
  - one cycle from D inputs to E outputs;
  - a load-use stall costs exactly one bubble cycle.
- Simultaneous pc_src_e and lu:
  - flush wins and stall_f/stall_d stay 0, so fetch redirects without a hold;
  - this combination cannot arise from the same EX instruction but must still be handled.
- Counters:
  - stall_cnt increments on each edge where rule 2 fires;
  - flush_cnt increments on each edge where rule 1 fires;
  - both saturate at all-ones, with no wrap;
  - they are cleared only by rst.
- Bubble invariant: a bubble never writes state downstream. RegWrite, MemWrite, Branch and Jump are all 0.
- Reset mid-operation: an in-flight stall or flush is abandoned, and the first post-reset edge follows the normal capture rules.

Decomposition:
- riscv_pkg holds:
  - the ctrl_s typedef (existing);
  - the RSRC_ALU/RSRC_MEM/RSRC_PC4 ResultSrc constants, moved out of the decoder into the package so both blocks share them;
  - an id_ex_s struct bundling all registered fields.
- One sub-module: hazard_detect. It is purely combinational and produces lu, stall_f, stall_d and flush_d from rs1_d, rs2_d, valid_d, rd_e, ctrl_e.ResultSrc, valid_e and pc_src_e.
- The register plus counters live in id_ex_stage.

Test Plan:
- Reset: assert rst mid-cycle with arbitrary inputs -> all outputs 0 immediately, valid_e=0, counters 0.
- Pass-through: an add with rs1=1, rs2=2, rd=3, rd1=5, rd2=7 -> next edge ctrl_e.RegWrite=1, rd_e=3, rd1_e=5, rd2_e=7, valid_e=1, no stall.
- Load-use:
  - stimulus: lw x5 in EX, then add using rs1=5 in D;
  - response: stall_f=stall_d=1 for one cycle, then a bubble in EX (ctrl_e='0);
  - next cycle: the add captured with stall deasserted, stall_cnt=1.
- x0 load: lw with rd=0 in EX and rs1_d=0 -> no stall.
- Branch flush: pc_src_e=1 with a valid add in D -> flush_d=1, next edge a bubble in EX, flush_cnt=1.
- Priority and saturation:
  - force lu and pc_src_e together -> stall_f=0, flush_d=1, flush_cnt increments;
  - preset CNT_W=2 and apply 5 flushes -> flush_cnt holds at 3.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: control bundle, ResultSrc encodings, ID/EX register layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    // Datapath width the registered bundle is laid out for; id_ex_stage XLEN must match.
    localparam int RV_XLEN = 32;

    // ResultSrc encodings, shared by the main decoder and the hazard interlock.
    localparam logic [1:0] RSRC_ALU = 2'b00;
    localparam logic [1:0] RSRC_MEM = 2'b01;
    localparam logic [1:0] RSRC_PC4 = 2'b10;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       Jump;
        logic       Branch;
        logic       ALUSrc;
        logic [1:0] ImmSrc;
    } ctrl_s;

    // Everything held in the ID/EX pipeline register. All-zero is a bubble.
    typedef struct packed {
        ctrl_s               ctrl;
        logic [2:0]          alu_ctrl;
        logic                valid;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [RV_XLEN-1:0]  rd1;
        logic [RV_XLEN-1:0]  rd2;
        logic [RV_XLEN-1:0]  imm_ext;
        logic [RV_XLEN-1:0]  pc;
        logic [RV_XLEN-1:0]  pc_plus4;
    } id_ex_s;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use and control-hazard interlock between Decode and Execute.
// Latency: purely combinational.
// Backpressure: stall_f_o/stall_d_o hold fetch and decode; flush_d_o squashes decode.
// Ports: D-side source indices and valid, E-side rd/ResultSrc/valid, pc_src_e_i
//        in; lu_o, stall_f_o, stall_d_o, flush_d_o out.
module hazard_detect
    import riscv_pkg::*;
(
    input  logic [4:0] rs1_d_i,
    input  logic [4:0] rs2_d_i,
    input  logic       valid_d_i,
    input  logic [4:0] rd_e_i,
    input  logic [1:0] result_src_e_i,
    input  logic       valid_e_i,
    input  logic       pc_src_e_i,
    output logic       lu_o,
    output logic       stall_f_o,
    output logic       stall_d_o,
    output logic       flush_d_o
);

    // rs2 is compared for every opcode: a spurious stall on an I-type is
    // cheaper than decoding which instructions really read rs2.
    assign lu_o = valid_e_i
                & (result_src_e_i == RSRC_MEM)
                & (rd_e_i != 5'd0)
                & valid_d_i
                & ((rs1_d_i == rd_e_i) | (rs2_d_i == rd_e_i));

    // A redirect discards D anyway, so holding fetch would only delay it.
    assign stall_f_o = lu_o & ~pc_src_e_i;
    assign stall_d_o = lu_o & ~pc_src_e_i;
    assign flush_d_o = pc_src_e_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble, branch flush and saturating event counters.
// Latency: one cycle D->E; a load-use stall costs exactly one bubble.
// Backpressure: stall_f/stall_d hold upstream on load-use; flush_d squashes D on redirect.
// Ports: clk/rst; *_d decode-side bundle in; *_e execute-side bundle out;
//        pc_src_e redirect in; stall_f/stall_d/flush_d hazard controls; stall_cnt/flush_cnt.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  ctrl_s            ctrl_d,
    input  logic [2:0]       alu_ctrl_d,
    input  logic             valid_d,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_d,
    input  logic [XLEN-1:0]  rd1_d,
    input  logic [XLEN-1:0]  rd2_d,
    input  logic [XLEN-1:0]  imm_ext_d,
    input  logic [XLEN-1:0]  pc_d,
    input  logic [XLEN-1:0]  pc_plus4_d,
    input  logic             pc_src_e,
    output ctrl_s            ctrl_e,
    output logic [2:0]       alu_ctrl_e,
    output logic             valid_e,
    output logic [4:0]       rs1_e,
    output logic [4:0]       rs2_e,
    output logic [4:0]       rd_e,
    output logic [XLEN-1:0]  rd1_e,
    output logic [XLEN-1:0]  rd2_e,
    output logic [XLEN-1:0]  imm_ext_e,
    output logic [XLEN-1:0]  pc_e,
    output logic [XLEN-1:0]  pc_plus4_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    id_ex_s            id_ex_q, id_ex_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              lu;

    hazard_detect u_hazard_detect (
        .rs1_d_i        (rs1_d),
        .rs2_d_i        (rs2_d),
        .valid_d_i      (valid_d),
        .rd_e_i         (id_ex_q.rd),
        .result_src_e_i (id_ex_q.ctrl.ResultSrc),
        .valid_e_i      (id_ex_q.valid),
        .pc_src_e_i     (pc_src_e),
        .lu_o           (lu),
        .stall_f_o      (stall_f),
        .stall_d_o      (stall_d),
        .flush_d_o      (flush_d)
    );

    always_comb begin
        id_ex_d     = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_src_e) begin
            // Wrong-path instruction in D is dropped; EX gets a bubble.
            if (flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
        end else if (lu) begin
            // D is held upstream and re-presented; EX gets a bubble.
            if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
            id_ex_d.ctrl     = valid_d ? ctrl_d : '0;
            id_ex_d.alu_ctrl = alu_ctrl_d;
            id_ex_d.valid    = valid_d;
            id_ex_d.rs1      = rs1_d;
            id_ex_d.rs2      = rs2_d;
            id_ex_d.rd       = rd_d;
            id_ex_d.rd1      = rd1_d;
            id_ex_d.rd2      = rd2_d;
            id_ex_d.imm_ext  = imm_ext_d;
            id_ex_d.pc       = pc_d;
            id_ex_d.pc_plus4 = pc_plus4_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            id_ex_q     <= id_ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ctrl_e     = id_ex_q.ctrl;
    assign alu_ctrl_e = id_ex_q.alu_ctrl;
    assign valid_e    = id_ex_q.valid;
    assign rs1_e      = id_ex_q.rs1;
    assign rs2_e      = id_ex_q.rs2;
    assign rd_e       = id_ex_q.rd;
    assign rd1_e      = id_ex_q.rd1;
    assign rd2_e      = id_ex_q.rd2;
    assign imm_ext_e  = id_ex_q.imm_ext;
    assign pc_e       = id_ex_q.pc;
    assign pc_plus4_e = id_ex_q.pc_plus4;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, load-use, x0, flush, priority, saturation.
// Latency: checks E outputs one cycle after D inputs are presented.
// Backpressure: models D holding its instruction while stall_d is asserted.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    ctrl_s       ctrl_d;
    logic [2:0]  alu_ctrl_d;
    logic        valid_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d;
    logic        pc_src_e;

    ctrl_s       ctrl_e;
    logic [2:0]  alu_ctrl_e;
    logic        valid_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
    logic        stall_f, stall_d, flush_d;
    logic [1:0]  stall_cnt, flush_cnt;

    ctrl_s       ctrl_e2;
    logic [2:0]  alu_ctrl_e2;
    logic        valid_e2;
    logic [4:0]  rs1_e2, rs2_e2, rd_e2;
    logic [31:0] rd1_e2, rd2_e2, imm_ext_e2, pc_e2, pc_plus4_e2;
    logic        stall_f2, stall_d2, flush_d2;
    logic [15:0] stall_cnt2, flush_cnt2;

    int n_checks = 0;
    int n_fails  = 0;

    ctrl_s ADD_C;
    ctrl_s LW_C;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .ctrl_d(ctrl_d), .alu_ctrl_d(alu_ctrl_d), .valid_d(valid_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
        .imm_ext_d(imm_ext_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .pc_src_e(pc_src_e),
        .ctrl_e(ctrl_e), .alu_ctrl_e(alu_ctrl_e), .valid_e(valid_e), .rs1_e(rs1_e),
        .rs2_e(rs2_e), .rd_e(rd_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e),
        .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage dut16 (
        .clk(clk), .rst(rst), .ctrl_d(ctrl_d), .alu_ctrl_d(alu_ctrl_d), .valid_d(valid_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
        .imm_ext_d(imm_ext_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .pc_src_e(pc_src_e),
        .ctrl_e(ctrl_e2), .alu_ctrl_e(alu_ctrl_e2), .valid_e(valid_e2), .rs1_e(rs1_e2),
        .rs2_e(rs2_e2), .rd_e(rd_e2), .rd1_e(rd1_e2), .rd2_e(rd2_e2), .imm_ext_e(imm_ext_e2),
        .pc_e(pc_e2), .pc_plus4_e(pc_plus4_e2), .stall_f(stall_f2), .stall_d(stall_d2),
        .flush_d(flush_d2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input ctrl_s c, input logic v, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] pc);
        ctrl_d     = c;
        alu_ctrl_d = 3'd0;
        valid_d    = v;
        rs1_d      = r1;
        rs2_d      = r2;
        rd_d       = rd;
        rd1_d      = d1;
        rd2_d      = d2;
        imm_ext_d  = 32'd4;
        pc_d       = pc;
        pc_plus4_d = pc + 32'd4;
    endtask

    initial begin
        ADD_C = '0;
        ADD_C.RegWrite  = 1'b1;
        ADD_C.ResultSrc = RSRC_ALU;
        LW_C = '0;
        LW_C.RegWrite  = 1'b1;
        LW_C.ResultSrc = RSRC_MEM;
        LW_C.ALUSrc    = 1'b1;

        rst      = 1'b1;
        pc_src_e = 1'b0;
        drive(ADD_C, 1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h40);
        tick();
        tick();
        chk("rst_valid_e", valid_e, 0);
        chk("rst_ctrl_e", ctrl_e, 0);
        chk("rst_rd1_e", rd1_e, 0);
        rst = 1'b0;

        // Pass-through add
        drive(ADD_C, 1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h100);
        #1;
        chk("pt_stall_f", stall_f, 0);
        tick();
        chk("pt_regwrite", ctrl_e.RegWrite, 1);
        chk("pt_rd_e", rd_e, 3);
        chk("pt_rd1_e", rd1_e, 5);
        chk("pt_rd2_e", rd2_e, 7);
        chk("pt_valid_e", valid_e, 1);
        chk("pt_pc_plus4_e", pc_plus4_e, 32'h104);
        chk("pt_stall_d", stall_d, 0);

        // Load-use on rs1
        drive(LW_C, 1'b1, 5'd1, 5'd0, 5'd5, 32'd0, 32'd0, 32'h104);
        tick();
        drive(ADD_C, 1'b1, 5'd5, 5'd2, 5'd6, 32'd11, 32'd13, 32'h108);
        #1;
        chk("lu_stall_f", stall_f, 1);
        chk("lu_stall_d", stall_d, 1);
        chk("lu_flush_d", flush_d, 0);
        tick();
        chk("lu_bubble_ctrl", ctrl_e, 0);
        chk("lu_bubble_valid", valid_e, 0);
        chk("lu_stall_cnt", stall_cnt, 1);
        chk("lu_stall_release", stall_f, 0);
        tick();
        chk("lu_add_ctrl", ctrl_e, ADD_C);
        chk("lu_add_rd", rd_e, 6);
        chk("lu_add_rd1", rd1_e, 11);
        chk("lu_stall_cnt_hold", stall_cnt, 1);

        // Load to x0 must not interlock
        drive(LW_C, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h10c);
        tick();
        drive(ADD_C, 1'b1, 5'd0, 5'd0, 5'd7, 32'd1, 32'd2, 32'h110);
        #1;
        chk("x0_stall_f", stall_f, 0);
        tick();
        chk("x0_rd_e", rd_e, 7);
        chk("x0_stall_cnt", stall_cnt, 1);

        // Invalid D: fields captured, control forced to zero
        drive(ADD_C, 1'b0, 5'd1, 5'd2, 5'd9, 32'd3, 32'd4, 32'h114);
        tick();
        chk("inv_ctrl", ctrl_e, 0);
        chk("inv_valid", valid_e, 0);
        chk("inv_rd_e", rd_e, 9);

        // Load-use on rs2
        drive(LW_C, 1'b1, 5'd1, 5'd0, 5'd8, 32'd0, 32'd0, 32'h118);
        tick();
        drive(ADD_C, 1'b1, 5'd1, 5'd8, 5'd10, 32'd0, 32'd0, 32'h11c);
        #1;
        chk("rs2_stall_d", stall_d, 1);
        tick();
        chk("rs2_bubble_valid", valid_e, 0);
        chk("rs2_stall_cnt", stall_cnt, 2);
        tick();
        chk("rs2_add_rd", rd_e, 10);

        // Branch flush
        drive(ADD_C, 1'b1, 5'd1, 5'd2, 5'd11, 32'd0, 32'd0, 32'h120);
        pc_src_e = 1'b1;
        #1;
        chk("br_flush_d", flush_d, 1);
        chk("br_stall_f", stall_f, 0);
        tick();
        chk("br_bubble_valid", valid_e, 0);
        chk("br_bubble_ctrl", ctrl_e, 0);
        chk("br_bubble_rd", rd_e, 0);
        chk("br_flush_cnt", flush_cnt, 1);

        // Flush and load-use together: flush wins, no stall
        pc_src_e = 1'b0;
        drive(LW_C, 1'b1, 5'd1, 5'd0, 5'd4, 32'd0, 32'd0, 32'h200);
        tick();
        drive(ADD_C, 1'b1, 5'd4, 5'd2, 5'd12, 32'd0, 32'd0, 32'h204);
        pc_src_e = 1'b1;
        #1;
        chk("pri_stall_f", stall_f, 0);
        chk("pri_stall_d", stall_d, 0);
        chk("pri_flush_d", flush_d, 1);
        tick();
        chk("pri_flush_cnt", flush_cnt, 2);
        chk("pri_stall_cnt", stall_cnt, 2);
        chk("pri_valid_e", valid_e, 0);

        // Three more flushes: 2-bit counter holds at 3, 16-bit reaches 5
        tick();
        chk("sat_flush_cnt_3", flush_cnt, 3);
        tick();
        tick();
        chk("sat_flush_cnt_hold", flush_cnt, 3);
        chk("wide_flush_cnt", flush_cnt2, 5);
        chk("wide_stall_cnt", stall_cnt2, 2);

        // Asynchronous reset mid-cycle
        pc_src_e = 1'b0;
        drive(ADD_C, 1'b1, 5'd1, 5'd2, 5'd13, 32'h55, 32'h66, 32'h300);
        tick();
        chk("pre_rst_valid", valid_e, 1);
        drive(ADD_C, 1'b1, 5'd3, 5'd3, 5'd14, 32'hdead, 32'hbeef, 32'h304);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid_e", valid_e, 0);
        chk("arst_rd1_e", rd1_e, 0);
        chk("arst_rd_e", rd_e, 0);
        chk("arst_stall_cnt", stall_cnt, 0);
        chk("arst_flush_cnt", flush_cnt, 0);
        chk("arst_wide_flush", flush_cnt2, 0);
        #2;
        rst = 1'b0;
        tick();
        chk("post_rst_rd_e", rd_e, 14);
        chk("post_rst_rd1_e", rd1_e, 32'hdead);
        chk("post_rst_valid", valid_e, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
